// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared response bytes and FSM state types for the UART command scheduler
package uart_sched_pkg;
  localparam logic [7:0] ACK_BYTE_D = 8'hA5;
  localparam logic [7:0] NAK_BYTE_D = 8'h5A;
  typedef enum logic {IN_IDLE, IN_CLR} in_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with combinational head, zero while empty
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    empty   = count == '0;
    full    = count == (AW+1)'(DEPTH);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    head    = empty ? '0 : mem[rd_ptr];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_cmd_scheduler.sv
// uart_cmd_scheduler: queues UART cmds for the consumer and arbitrates ACK/NAK bytes onto the transmitter
module uart_cmd_scheduler
  import uart_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_D,
  parameter logic [7:0] NAK_BYTE = NAK_BYTE_D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_in,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic [15:0] cmd_out,
  output logic        cmd_vld,
  input  logic        cmd_ack,
  input  logic        done,
  output logic        trmt,
  output logic [7:0]  resp,
  input  logic        tx_done,
  output logic        ack_lost
);
  localparam int AW = $clog2(DEPTH);
  in_state_t in_state, in_next;
  tx_state_t tx_state, tx_next;
  logic take, push, drop, pop, full, empty;
  logic [AW:0] count;
  logic [2:0] ack_cnt;
  logic nak_pend, nak_go, ack_go, ack_inc;
  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(cmd_in),
    .full(full), .empty(empty), .count(count), .head(cmd_out)
  );
  always_comb begin
    take        = (in_state == IN_IDLE) & cmd_rdy;
    in_next     = take ? IN_CLR : IN_IDLE;
    clr_cmd_rdy = in_state == IN_CLR;
    cmd_vld     = count != '0;
    pop         = cmd_ack & ~empty;
    push        = take & (~full | pop);
    drop        = take & ~push;
  end
  // A drop or done seen while idle launches directly, giving one clock to trmt
  always_comb begin
    nak_go  = (tx_state == TX_IDLE) & (nak_pend | drop);
    ack_go  = (tx_state == TX_IDLE) & ~nak_go & ((ack_cnt != '0) | done);
    ack_inc = done & ((ack_cnt != 3'd7) | ack_go);
    tx_next = (nak_go | ack_go) ? TX_BUSY :
              ((tx_state == TX_BUSY) & tx_done) ? TX_IDLE : tx_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_state <= IN_IDLE;
      tx_state <= TX_IDLE;
      ack_cnt  <= '0;
      nak_pend <= 1'b0;
      ack_lost <= 1'b0;
      trmt     <= 1'b0;
      resp     <= '0;
    end else begin
      in_state <= in_next;
      tx_state <= tx_next;
      ack_cnt  <= ack_cnt + 3'(ack_inc) - 3'(ack_go);
      nak_pend <= (nak_pend | drop) & ~nak_go;
      ack_lost <= ack_lost | (done & ~ack_inc);
      trmt     <= nak_go | ack_go;
      if (nak_go) resp <= NAK_BYTE;
      else if (ack_go) resp <= ACK_BYTE;
    end
endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// tb_uart_cmd_scheduler: directed scenarios plus randomized traffic against a queue-based reference model
module tb_uart_cmd_scheduler;
  localparam int DEPTH = 4;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'h5A;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] cmd_in = '0;
  logic cmd_rdy = 1'b0, cmd_ack = 1'b0, done = 1'b0, tx_done = 1'b0;
  logic clr_cmd_rdy, cmd_vld, trmt, ack_lost;
  logic [15:0] cmd_out;
  logic [7:0] resp;
  int vectors = 0, errors = 0;
  logic [7:0] sent [$];
  logic [15:0] q [$];
  int m_acks;
  bit m_nakp, m_busy, m_trmt, m_clr, m_lost;
  logic [7:0] m_resp;

  uart_cmd_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .cmd_out(cmd_out), .cmd_vld(cmd_vld), .cmd_ack(cmd_ack), .done(done), .trmt(trmt),
    .resp(resp), .tx_done(tx_done), .ack_lost(ack_lost)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (trmt) sent.push_back(resp);

  task automatic model_reset;
    q.delete();
    m_acks = 0; m_nakp = 0; m_busy = 0; m_trmt = 0; m_clr = 0; m_lost = 0; m_resp = '0;
  endtask

  // advance one clock: update the model from the current inputs, then sample #1 after the edge
  task automatic tick;
    bit take, popping, drop, nak_go, ack_go;
    if (!rst_n) model_reset();
    else begin
      take = !m_clr && cmd_rdy;
      popping = cmd_ack && q.size() > 0;
      drop = take && q.size() == DEPTH && !popping;
      if (popping) void'(q.pop_front());
      if (take && !drop) q.push_back(cmd_in);
      m_clr = take;
      nak_go = !m_busy && (m_nakp || drop);
      ack_go = !m_busy && !nak_go && (m_acks > 0 || done);
      m_trmt = nak_go || ack_go;
      if (nak_go) begin m_resp = NAK; m_nakp = 0; end
      else m_nakp = m_nakp || drop;
      if (ack_go) begin m_resp = ACK; m_acks = m_acks + int'(done) - 1; end
      else if (done) begin
        if (m_acks == 7) m_lost = 1;
        else m_acks++;
      end
      m_busy = m_trmt || (m_busy && !tx_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input logic [15:0] c);
    cmd_in = c; cmd_rdy = 1'b1; tick(); cmd_rdy = 1'b0; tick();
  endtask

  task automatic drain(input int n);
    tx_done = 1'b1; repeat (n) tick(); tx_done = 1'b0;
  endtask

  task automatic test_reset;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if ({clr_cmd_rdy, cmd_vld, cmd_out, trmt, resp, ack_lost} !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", {clr_cmd_rdy, cmd_vld, cmd_out, trmt, resp, ack_lost}); end
    rst_n = 1'b1; tick();
    vectors++; if ({clr_cmd_rdy, cmd_vld, cmd_out, trmt, resp, ack_lost} !== '0) begin errors++; $display("FAIL reset_release: got %h want 0", {clr_cmd_rdy, cmd_vld, cmd_out, trmt, resp, ack_lost}); end
  endtask

  task automatic test_single_cmd;
    cmd_in = 16'hF00F; cmd_rdy = 1'b1; tick(); cmd_rdy = 1'b0;
    vectors++; if (clr_cmd_rdy !== 1'b1) begin errors++; $display("FAIL single_clr: got %b want 1", clr_cmd_rdy); end
    vectors++; if (cmd_vld !== 1'b1) begin errors++; $display("FAIL single_vld: got %b want 1", cmd_vld); end
    vectors++; if (cmd_out !== 16'hF00F) begin errors++; $display("FAIL single_out: got %h want f00f", cmd_out); end
    tick();
    vectors++; if (clr_cmd_rdy !== 1'b0) begin errors++; $display("FAIL single_clr_pulse: got %b want 0", clr_cmd_rdy); end
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    vectors++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL single_pop: got %b want 0", cmd_vld); end
  endtask

  task automatic test_fifo_full_nak;
    for (int i = 1; i <= 4; i++) push_cmd(16'(i));
    cmd_in = 16'h0005; cmd_rdy = 1'b1; tick(); cmd_rdy = 1'b0;
    vectors++; if (trmt !== 1'b1 || resp !== NAK) begin errors++; $display("FAIL full_nak: got trmt=%b resp=%h want 1/5a", trmt, resp); end
    vectors++; if (cmd_out !== 16'h0001) begin errors++; $display("FAIL full_head: got %h want 0001", cmd_out); end
    tick();
    vectors++; if (trmt !== 1'b0 || resp !== NAK) begin errors++; $display("FAIL full_hold: got trmt=%b resp=%h want 0/5a", trmt, resp); end
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      vectors++; if (cmd_out !== 16'(i)) begin errors++; $display("FAIL full_order%0d: got %h want %h", i, cmd_out, 16'(i)); end
      cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    end
    vectors++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL full_empty: got %b want 0", cmd_vld); end
  endtask

  task automatic test_ack_burst;
    sent.delete();
    done = 1'b1; tick(); done = 1'b0;
    vectors++; if (trmt !== 1'b1 || resp !== ACK) begin errors++; $display("FAIL burst_first: got trmt=%b resp=%h want 1/a5", trmt, resp); end
    for (int i = 0; i < 3; i++) begin
      done = 1'b1; tick(); done = 1'b0; tick();
      vectors++; if (trmt !== 1'b0 || resp !== ACK) begin errors++; $display("FAIL burst_hold%0d: got trmt=%b resp=%h want 0/a5", i, trmt, resp); end
    end
    drain(20);
    vectors++; if (sent.size() != 4) begin errors++; $display("FAIL burst_count: got %0d want 4", sent.size()); end
    foreach (sent[i]) begin
      vectors++; if (sent[i] !== ACK) begin errors++; $display("FAIL burst_byte%0d: got %h want a5", i, sent[i]); end
    end
    vectors++; if (ack_lost !== 1'b0) begin errors++; $display("FAIL burst_lost: got %b want 0", ack_lost); end
  endtask

  task automatic test_nak_before_ack;
    for (int i = 0; i < 4; i++) push_cmd(16'h1000 + 16'(i));
    sent.delete();
    cmd_in = 16'hBEEF; cmd_rdy = 1'b1; done = 1'b1; tick(); cmd_rdy = 1'b0; done = 1'b0;
    vectors++; if (trmt !== 1'b1 || resp !== NAK) begin errors++; $display("FAIL order_first: got trmt=%b resp=%h want 1/5a", trmt, resp); end
    drain(10);
    vectors++; if (sent.size() != 2) begin errors++; $display("FAIL order_count: got %0d want 2", sent.size()); end
    else begin
      vectors++; if (sent[0] !== NAK || sent[1] !== ACK) begin errors++; $display("FAIL order_seq: got %h,%h want 5a,a5", sent[0], sent[1]); end
    end
    cmd_ack = 1'b1; repeat (4) tick(); cmd_ack = 1'b0;
    vectors++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL order_empty: got %b want 0", cmd_vld); end
  endtask

  task automatic test_ack_saturation;
    sent.delete();
    repeat (9) begin done = 1'b1; tick(); done = 1'b0; tick(); end
    vectors++; if (ack_lost !== 1'b1) begin errors++; $display("FAIL sat_lost: got %b want 1", ack_lost); end
    drain(30);
    vectors++; if (sent.size() != 8) begin errors++; $display("FAIL sat_count: got %0d want 8", sent.size()); end
  endtask

  task automatic test_async_reset;
    push_cmd(16'h1111);
    push_cmd(16'h2222);
    done = 1'b1; tick(); done = 1'b0;
    #3 rst_n = 1'b0;
    #1 model_reset();
    vectors++; if ({clr_cmd_rdy, cmd_out, trmt, resp, ack_lost} !== '0) begin errors++; $display("FAIL areset_outs: got %h want 0", {clr_cmd_rdy, cmd_out, trmt, resp, ack_lost}); end
    vectors++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL areset_vld: got %b want 0", cmd_vld); end
    @(posedge clk); #1 rst_n = 1'b1;
    cmd_in = 16'h596A; cmd_rdy = 1'b1; tick(); cmd_rdy = 1'b0;
    vectors++; if (cmd_vld !== 1'b1 || cmd_out !== 16'h596A) begin errors++; $display("FAIL areset_cmd: got vld=%b out=%h want 1/596a", cmd_vld, cmd_out); end
    tick();
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    vectors++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL areset_pop: got %b want 0", cmd_vld); end
  endtask

  task automatic test_random;
    int p_ack, p_done, p_tx;
    for (int i = 0; i < 1500; i++) begin
      case ((i / 250) % 3)
        0: begin p_ack = 60; p_done = 15; p_tx = 50; end
        1: begin p_ack = 10; p_done = 30; p_tx = 30; end
        default: begin p_ack = 35; p_done = 70; p_tx = 5; end
      endcase
      cmd_rdy = $urandom_range(0, 99) < 45;
      cmd_in  = 16'($urandom);
      cmd_ack = $urandom_range(0, 99) < p_ack;
      done    = $urandom_range(0, 99) < p_done;
      tx_done = $urandom_range(0, 99) < p_tx;
      tick();
      vectors++; if (clr_cmd_rdy !== m_clr) begin errors++; $display("FAIL rnd_clr @%0d: got %b want %b", i, clr_cmd_rdy, m_clr); end
      vectors++; if (cmd_vld !== (q.size() > 0)) begin errors++; $display("FAIL rnd_vld @%0d: got %b want %b", i, cmd_vld, q.size() > 0); end
      vectors++; if (cmd_out !== (q.size() > 0 ? q[0] : 16'h0)) begin errors++; $display("FAIL rnd_out @%0d: got %h want %h", i, cmd_out, q.size() > 0 ? q[0] : 16'h0); end
      vectors++; if (trmt !== m_trmt) begin errors++; $display("FAIL rnd_trmt @%0d: got %b want %b", i, trmt, m_trmt); end
      vectors++; if (resp !== m_resp) begin errors++; $display("FAIL rnd_resp @%0d: got %h want %h", i, resp, m_resp); end
      vectors++; if (ack_lost !== m_lost) begin errors++; $display("FAIL rnd_lost @%0d: got %b want %b", i, ack_lost, m_lost); end
    end
    {cmd_rdy, cmd_ack, done, tx_done} = '0;
  endtask

  initial begin
    test_reset();
    test_single_cmd();
    test_fifo_full_nak();
    test_ack_burst();
    test_nak_before_ack();
    test_ack_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
